// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: round-robin ALU/MEM arbitration onto a single
// registered write port, plus a destination scoreboard for RAW/WAW stalls in decode.
module rf_wb_scheduler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned REG_SIZE   = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [REG_SIZE-1:0]   iss_rd,
    output logic                  iss_ready,
    input  logic [REG_SIZE-1:0]   chk_rs1,
    input  logic [REG_SIZE-1:0]   chk_rs2,
    output logic                  chk_rs1_busy,
    output logic                  chk_rs2_busy,
    input  logic                  alu_valid,
    input  logic [REG_SIZE-1:0]   alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_SIZE-1:0]   mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    output logic                  rf_we,
    output logic [REG_SIZE-1:0]   rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [REG_COUNT-1:0]  busy_vec,
    output logic                  spurious_wb
);

    typedef enum logic {
        GntAlu = 1'b0,
        GntMem = 1'b1
    } grant_e;

    logic [REG_COUNT-1:0]  busy_q, busy_d;
    grant_e                last_grant_q, last_grant_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_SIZE-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    // Contention goes to whichever side did not win last time.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!rst) begin
            alu_ready = alu_valid & (~mem_valid | (last_grant_q == GntMem));
            mem_ready = mem_valid & (~alu_valid | (last_grant_q == GntAlu));
        end
    end

    assign iss_ready    = ~rst & iss_valid & ~busy_q[iss_rd];
    assign chk_rs1_busy = busy_q[chk_rs1];
    assign chk_rs2_busy = busy_q[chk_rs2];

    always_comb begin
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        if (alu_ready) begin
            last_grant_d = GntAlu;
            rf_we_d      = (alu_rd != '0);
            rf_waddr_d   = alu_rd;
            rf_wdata_d   = alu_data;
        end else if (mem_ready) begin
            last_grant_d = GntMem;
            rf_we_d      = (mem_rd != '0);
            rf_waddr_d   = mem_rd;
            rf_wdata_d   = mem_data;
        end
    end

    // Clear before set so an issue to a non-busy register being written still marks it busy.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (iss_ready) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            last_grant_q <= GntMem;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign busy_vec    = busy_q;
    assign spurious_wb = ~rst & rf_we_q & ~busy_q[rf_waddr_q];

endmodule
